// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite engine.
// Screen geometry, colour type, game states and score ceiling.
package vga_pkg;

    localparam int VGA_W     = 640;
    localparam int VGA_H     = 480;
    localparam int SCORE_MAX = 99999;

    typedef logic [11:0] colour_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

endpackage

// File: rtl/obstacle_channel.sv
// One scrolling obstacle: x position with wrap/reload, box test
// and sprite-local row/col for the current pixel.
module obstacle_channel #(
    parameter int X0      = 550,
    parameter int SPAWN_X = 550,
    parameter int SPEED   = 1,
    parameter int OB_W    = 42,
    parameter int OB_H    = 70,
    parameter int GROUND  = 335
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        reload,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    output logic [31:0] obs_x,
    output logic        in_box,
    output logic [12:0] row,
    output logic [12:0] col
);

    localparam logic [31:0] TOP = 32'(GROUND - OB_H);

    logic [31:0] obs_x_q, obs_x_d;
    logic [31:0] x32, y32;

    assign x32   = {22'd0, x};
    assign y32   = {23'd0, y};
    assign obs_x = obs_x_q;

    // Wrap is decided on the current position so x never drops below 10.
    always_comb begin
        obs_x_d = obs_x_q;
        if (reload) begin
            obs_x_d = 32'(X0);
        end else if (step) begin
            if (obs_x_q < 32'(SPEED + 10)) begin
                obs_x_d = 32'(SPAWN_X);
            end else begin
                obs_x_d = obs_x_q - 32'(SPEED);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obs_x_q <= 32'(X0);
        end else begin
            obs_x_q <= obs_x_d;
        end
    end

    always_comb begin
        in_box = (x32 >= obs_x_q)
              && ({1'b0, x32} < ({1'b0, obs_x_q} + 33'(OB_W)))
              && (y32 >= TOP)
              && (y32 < 32'(GROUND));
        row = 13'(y32 - TOP);
        col = 13'(x32 - obs_x_q);
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// Player/obstacle/background compositor with collision detection,
// IDLE/RUN/OVER game FSM and frame-based score.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int      N_OBS   = 3,
    parameter int      PL_W    = 60,
    parameter int      PL_H    = 60,
    parameter int      OB_W    = 42,
    parameter int      OB_H    = 70,
    parameter int      GROUND  = 335,
    parameter int      SPAWN_X = 550,
    parameter int      SPACING = 200,
    parameter int      SPEED   = 1,
    parameter colour_t FG      = 12'h000,
    parameter colour_t BG      = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        frame_end,
    input  logic        active,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [31:0] player_x,
    input  logic [31:0] player_y,
    input  logic        start,
    output logic [12:0] pl_addr,
    input  logic        pl_data,
    output logic [12:0] ob_addr,
    input  logic        ob_data,
    input  logic        bg_data,
    output logic [11:0] rgb,
    output logic        game_over,
    output logic [2:0]  hit_id,
    output logic [16:0] score
);

    state_t      state_q, state_d;
    logic        start_q;
    logic [16:0] score_q, score_d;
    logic [2:0]  hit_id_q, hit_id_d;
    colour_t     rgb_q, rgb_d;

    logic [31:0] x32, y32;
    logic        pl_in_box;
    logic [12:0] pl_row, pl_col;

    logic [N_OBS-1:0] ch_in_box;
    logic [31:0]      ch_x   [N_OBS];
    logic [12:0]      ch_row [N_OBS];
    logic [12:0]      ch_col [N_OBS];

    logic        any_ob;
    logic [2:0]  sel;
    logic [12:0] sel_row, sel_col;
    logic        pl_ink, ob_ink, collide;
    logic        frame_tick, restart, step;

    assign x32 = {22'd0, x};
    assign y32 = {23'd0, y};

    // 33-bit sums keep the right/bottom edges from wrapping.
    always_comb begin
        pl_in_box = (x32 >= player_x)
                 && ({1'b0, x32} < ({1'b0, player_x} + 33'(PL_W)))
                 && (y32 >= player_y)
                 && ({1'b0, y32} < ({1'b0, player_y} + 33'(PL_H)));
        pl_row  = 13'(y32 - player_y);
        pl_col  = 13'(x32 - player_x);
        pl_addr = pl_in_box ? (pl_row * 13'(PL_W) + pl_col) : '0;
    end

    for (genvar i = 0; i < N_OBS; i++) begin : g_ch
        obstacle_channel #(
            .X0      (SPAWN_X + i * SPACING),
            .SPAWN_X (SPAWN_X),
            .SPEED   (SPEED),
            .OB_W    (OB_W),
            .OB_H    (OB_H),
            .GROUND  (GROUND)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .step   (step),
            .reload (restart),
            .x      (x),
            .y      (y),
            .obs_x  (ch_x[i]),
            .in_box (ch_in_box[i]),
            .row    (ch_row[i]),
            .col    (ch_col[i])
        );
    end

    // Scan high to low so the lowest covering channel wins.
    always_comb begin
        sel     = '0;
        sel_row = '0;
        sel_col = '0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (ch_in_box[i]) begin
                sel     = 3'(i);
                sel_row = ch_row[i];
                sel_col = ch_col[i];
            end
        end
    end

    assign any_ob  = |ch_in_box;
    assign ob_addr = any_ob ? (sel_row * 13'(OB_W) + sel_col) : '0;

    assign pl_ink     = pl_in_box & pl_data;
    assign ob_ink     = any_ob & ob_data;
    assign collide    = pix_ce & active & pl_ink & ob_ink;
    assign frame_tick = frame_end & pix_ce;
    assign restart    = (state_q == OVER) & start & ~start_q;
    assign step       = (state_q == RUN) & frame_tick & ~collide;

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hit_id_d = hit_id_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (collide) begin
                    state_d  = OVER;
                    hit_id_d = sel;
                end else if (frame_tick) begin
                    if (score_q < 17'(SCORE_MAX)) score_d = score_q + 17'd1;
                end
            end
            OVER: begin
                if (restart) begin
                    state_d  = RUN;
                    score_d  = '0;
                    hit_id_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rgb_d = rgb_q;
        if (pix_ce) begin
            if (!active) begin
                rgb_d = '0;
            end else if (pl_ink || ob_ink || bg_data) begin
                rgb_d = FG;
            end else begin
                rgb_d = BG;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            score_q  <= '0;
            hit_id_q <= '0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            score_q  <= score_d;
            hit_id_q <= hit_id_d;
            rgb_q    <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign game_over = (state_q == OVER);
    assign hit_id    = hit_id_q;
    assign score     = score_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: compositing vector table plus
// hand-written game-flow sequences with an rgb scoreboard.
module tb_vga_sprite_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce, frame_end, active, start;
    logic        pl_data, ob_data, bg_data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [31:0] player_x, player_y;
    logic [12:0] pl_addr, ob_addr;
    logic [11:0] rgb;
    logic        game_over;
    logic [2:0]  hit_id;
    logic [16:0] score;

    vga_sprite_engine dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .frame_end (frame_end),
        .active    (active),
        .x         (x),
        .y         (y),
        .player_x  (player_x),
        .player_y  (player_y),
        .start     (start),
        .pl_addr   (pl_addr),
        .pl_data   (pl_data),
        .ob_addr   (ob_addr),
        .ob_data   (ob_data),
        .bg_data   (bg_data),
        .rgb       (rgb),
        .game_over (game_over),
        .hit_id    (hit_id),
        .score     (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic        act;
        logic        pd;
        logic        od;
        logic        bd;
        logic [11:0] rgb;
        logic [12:0] pa;
        logic [12:0] oa;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          exp_x[3];
    int          exp_score;
    bit          below10;

    function automatic vec_t mk(int px, int py, logic a, logic p, logic o,
                                logic b, logic [11:0] c, logic [12:0] pa,
                                logic [12:0] oa);
        vec_t v;
        v.x = px; v.y = py; v.act = a; v.pd = p; v.od = o; v.bd = b;
        v.rgb = c; v.pa = pa; v.oa = oa;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic chk_obs(input string nm);
        chk({nm, "_x0"}, dut.ch_x[0], 32'(exp_x[0]));
        chk({nm, "_x1"}, dut.ch_x[1], 32'(exp_x[1]));
        chk({nm, "_x2"}, dut.ch_x[2], 32'(exp_x[2]));
    endtask

    task automatic pix(input int px, input int py, input logic a,
                       input logic p, input logic o, input logic b,
                       input logic fe, input logic [11:0] e);
        x = 10'(px); y = 9'(py); active = a;
        pl_data = p; ob_data = o; bg_data = b; frame_end = fe;
        repeat (3) tick();
        pix_ce = 1'b1;
        exp_q.push_back(e);
        tick();
        pix_ce = 1'b0;
        frame_end = 1'b0;
        chk("pix_rgb", 32'(rgb), 32'(exp_q.pop_front()));
    endtask

    task automatic model_frame();
        for (int i = 0; i < 3; i++) begin
            if (exp_x[i] < 11) exp_x[i] = 550;
            else exp_x[i] = exp_x[i] - 1;
        end
        if (exp_score < 99999) exp_score++;
    endtask

    task automatic frame(input bit run);
        pix(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        if (run) model_frame();
    endtask

    task automatic reset_model();
        exp_x[0] = 550; exp_x[1] = 750; exp_x[2] = 950;
        exp_score = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pix_ce = 0; frame_end = 0; active = 0; start = 0;
        pl_data = 0; ob_data = 0; bg_data = 0; x = '0; y = '0;
        player_x = 540; player_y = 275;
        reset_model();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_hit", 32'(hit_id), 0);
        chk_obs("rst");

        // Player at (540,275); ch0 box x 550..591, y 265..334.
        tbl.push_back(mk(545, 280, 1, 1, 0, 0, 12'h000, 305, 0));
        tbl.push_back(mk(545, 280, 1, 0, 0, 1, 12'h000, 305, 0));
        tbl.push_back(mk(545, 280, 1, 0, 1, 0, 12'hFFF, 305, 0));
        tbl.push_back(mk(560, 300, 1, 1, 1, 0, 12'h000, 1520, 1480));
        tbl.push_back(mk(560, 300, 1, 0, 1, 0, 12'h000, 1520, 1480));
        tbl.push_back(mk(560, 300, 1, 0, 0, 0, 12'hFFF, 1520, 1480));
        tbl.push_back(mk(560, 300, 0, 1, 0, 0, 12'h000, 1520, 1480));
        tbl.push_back(mk(100, 100, 1, 1, 1, 0, 12'hFFF, 0, 0));
        tbl.push_back(mk(100, 100, 1, 0, 0, 1, 12'h000, 0, 0));
        tbl.push_back(mk(600, 300, 1, 1, 0, 0, 12'hFFF, 0, 0));
        tbl.push_back(mk(539, 300, 1, 1, 0, 0, 12'hFFF, 0, 0));
        tbl.push_back(mk(591, 300, 1, 0, 1, 0, 12'h000, 1551, 1511));
        tbl.push_back(mk(592, 300, 1, 0, 1, 0, 12'hFFF, 1552, 0));
        tbl.push_back(mk(560, 335, 1, 0, 1, 0, 12'hFFF, 0, 0));
        tbl.push_back(mk(560, 265, 1, 0, 1, 0, 12'h000, 0, 10));
        tbl.push_back(mk(751, 266, 1, 0, 1, 0, 12'h000, 0, 43));
        tbl.push_back(mk(100, 100, 0, 0, 0, 0, 12'h000, 0, 0));

        foreach (tbl[i]) begin
            x = 10'(tbl[i].x); y = 9'(tbl[i].y); active = tbl[i].act;
            pl_data = tbl[i].pd; ob_data = tbl[i].od; bg_data = tbl[i].bd;
            #1;
            chk($sformatf("v%0d_pa", i), 32'(pl_addr), 32'(tbl[i].pa));
            chk($sformatf("v%0d_oa", i), 32'(ob_addr), 32'(tbl[i].oa));
            repeat (2) tick();
            pix_ce = 1'b1;
            exp_q.push_back(tbl[i].rgb);
            tick();
            pix_ce = 1'b0;
            chk($sformatf("v%0d_rgb", i), 32'(rgb), 32'(exp_q.pop_front()));
        end
        chk("idle_no_over", 32'(game_over), 0);
        chk("idle_score", 32'(score), 0);

        // 100 frames with the player well clear of all obstacles.
        player_x = 0; player_y = 0;
        start = 1'b1;
        tick();
        pix(10, 10, 1, 1, 1, 0, 0, 12'h000);
        for (int f = 0; f < 100; f++) frame(1);
        chk("run100_score", 32'(score), 100);
        chk("run100_x0", dut.ch_x[0], 450);
        chk_obs("run100");
        chk("run100_over", 32'(game_over), 0);

        // Walk ch0 down to 10, then one more frame wraps it.
        below10 = 0;
        while (exp_x[0] != 10) begin
            frame(1);
            if (dut.ch_x[0] < 10) below10 = 1;
        end
        chk("x0_at10", dut.ch_x[0], 10);
        frame(1);
        chk("x0_wrap", dut.ch_x[0], 550);
        chk("never_below10", 32'(below10), 0);
        chk_obs("wrap");
        chk("wrap_score", 32'(score), 32'(exp_score));

        // Collide with ch1 only, on the same clk as frame_end.
        player_x = 32'(exp_x[1] + 10); player_y = 275;
        pix(exp_x[1] + 20, 300, 1, 1, 1, 0, 1, 12'h000);
        chk("hit_over", 32'(game_over), 1);
        chk("hit_id1", 32'(hit_id), 1);
        chk("hit_score", 32'(score), 32'(exp_score));
        chk_obs("hit");
        frame(0);
        chk("over_score", 32'(score), 32'(exp_score));
        chk_obs("over");
        chk("over_held", 32'(game_over), 1);

        // Start rising edge together with a collision pixel in OVER.
        start = 1'b0;
        repeat (2) tick();
        x = 10'(exp_x[1] + 20); y = 9'd300; active = 1;
        pl_data = 1; ob_data = 1; bg_data = 0;
        repeat (3) tick();
        start = 1'b1;
        pix_ce = 1'b1;
        exp_q.push_back(12'h000);
        tick();
        pix_ce = 1'b0;
        chk("rs_rgb", 32'(rgb), 32'(exp_q.pop_front()));
        reset_model();
        chk("rs_over", 32'(game_over), 0);
        chk("rs_score", 32'(score), 0);
        chk("rs_hit", 32'(hit_id), 0);
        chk_obs("rs");
        repeat (3) tick();
        chk("rs_still_run", 32'(game_over), 0);
        frame(1);
        chk("rs_score1", 32'(score), 1);
        chk_obs("rs_f1");

        // Collide with ch0, then reset in the middle of a clk.
        player_x = 555; player_y = 275;
        pix(560, 300, 1, 1, 1, 0, 0, 12'h000);
        chk("hit0_over", 32'(game_over), 1);
        chk("hit0_id", 32'(hit_id), 0);
        pix(100, 100, 1, 0, 0, 0, 0, 12'hFFF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rgb", 32'(rgb), 0);
        chk("mid_score", 32'(score), 0);
        chk("mid_over", 32'(game_over), 0);
        chk("mid_hit", 32'(hit_id), 0);
        reset_model();
        chk_obs("mid");
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rgb", 32'(rgb), 0);
        chk("post_over", 32'(game_over), 0);
        chk_obs("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
